inv_round_engine: RTL

//  Iterative inverse of the 16-round Feistel stack; the decrypt direction of the DES datapath.

---
 rtl/des_pkg.sv | 32 +++
 rtl/round.sv | 40 ++++
 rtl/inv_round_engine.sv | 97 +++++++++
 3 files changed

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared DES datapath types, constants and Feistel round tables
package des_pkg;

   localparam int ROUND_COUNT = 16;
   localparam int BLOCK_W     = 64;
   localparam int HALF_W      = 32;
   localparam int KEY_W       = 48;

   typedef logic [KEY_W-1:0]   round_key_t;
   typedef logic [BLOCK_W-1:0] block_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} inv_state_t;

   // One box per element, rows concatenated; the entry index is {outer bits, inner bits}, entry 0 leftmost
   localparam logic [0:63][3:0] SBOX [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175BE3A06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
   };

   // P permutation, 1-based source bit numbers counted from the MSB
   localparam int PERM [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
   };

endpackage

// File: rtl/round.sv
// rtl/round.sv - one DES Feistel round: {L,R} -> {R, L ^ f(R,K)}
module round
   import des_pkg::*;
(
   input  block_t     block,
   input  round_key_t round_key,
   output block_t     next_block
);

   logic [HALF_W-1:0] l;
   logic [HALF_W-1:0] r;
   logic [HALF_W-1:0] s;
   logic [HALF_W-1:0] f;
   logic [KEY_W-1:0]  x;
   logic [5:0]        six;

   always_comb begin
      l   = block[BLOCK_W-1:HALF_W];
      r   = block[HALF_W-1:0];
      x   = '0;
      s   = '0;
      f   = '0;
      six = '0;
      // Expansion: group g repeats the neighbouring bit on each side, wrapping around the word
      for (int j = 0; j < KEY_W; j++) begin
         x[6'(KEY_W - 1 - j)] = r[5'(31 - ((4 * (j / 6) + (j % 6) + 31) % 32))];
      end
      x = x ^ round_key;
      for (int g = 0; g < 8; g++) begin
         six = x[6'(47 - 6 * g) -: 6];
         s[5'(31 - 4 * g) -: 4] = SBOX[3'(g)][{six[5], six[0], six[4:1]}];
      end
      for (int n = 0; n < HALF_W; n++) begin
         f[5'(31 - n)] = s[5'(32 - PERM[5'(n)])];
      end
   end

   assign next_block = {r, l ^ f};

endmodule

// File: rtl/inv_round_engine.sv
// rtl/inv_round_engine.sv - iterative inverse of the 16-round DES Feistel stack, one round per clock
module inv_round_engine
   import des_pkg::*;
#(
   parameter int NUM_ROUNDS  = 16,
   parameter bit SWAP_HALVES = 1'b1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [BLOCK_W-1:0]                cipher_i,
   input  logic [0:ROUND_COUNT-1][KEY_W-1:0] round_keys,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [BLOCK_W-1:0]                plain_o,
   output logic                              out_valid,
   input  logic                              out_ready
);

   generate
      if (NUM_ROUNDS != ROUND_COUNT) begin : g_bad_rounds
         $error("inv_round_engine: NUM_ROUNDS must be 16");
      end
   endgenerate

   inv_state_t                        state;
   inv_state_t                        state_nxt;
   logic [3:0]                        cnt;
   block_t                            data_q;
   block_t                            round_out;
   logic [0:ROUND_COUNT-1][KEY_W-1:0] keys_q;
   round_key_t                        cur_key;
   logic                              accept;

   // Undoing the forward stack's per-round swap reduces to one swap at each end
   function automatic block_t swap_halves(input block_t b);
      return SWAP_HALVES ? {b[HALF_W-1:0], b[BLOCK_W-1:HALF_W]} : b;
   endfunction

   assign accept  = in_valid & in_ready;
   assign cur_key = keys_q[4'(ROUND_COUNT - 1) - cnt];

   round u_round (
      .block      (data_q),
      .round_key  (cur_key),
      .next_block (round_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (cnt == 4'(ROUND_COUNT - 1)) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // plain_o is gated by the registered state so intermediate rounds never reach the output
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      plain_o   = '0;
      case (state)
         IDLE: in_ready = ~rst;
         DONE: begin
            in_ready  = out_ready & ~rst;
            out_valid = 1'b1;
            plain_o   = swap_halves(data_q);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         data_q <= '0;
         keys_q <= '0;
      end else if (accept) begin
         data_q <= swap_halves(cipher_i);
         keys_q <= round_keys;
         cnt    <= '0;
      end else if (state == RUN) begin
         data_q <= round_out;
         cnt    <= cnt + 4'd1;
      end
   end

endmodule
